// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin arbiter that hands the BRAM port to one of
// three burst requesters (input-buffer load, weight-buffer load, writeback).
//
// state | meaning
// IDLE  | no grant held; sample req and arbitrate
// BURST | one beat per cycle at memaddr, len beats in total
// DRAIN | last read beat returns, done pulses, grant released at next edge
module bram_port_arbiter #(
  parameter int width = 8,
  parameter int addrw = 10,
  parameter int lenw  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [addrw-1:0] base0,
  input  logic [addrw-1:0] base1,
  input  logic [addrw-1:0] base2,
  input  logic [lenw-1:0]  len0,
  input  logic [lenw-1:0]  len1,
  input  logic [lenw-1:0]  len2,
  input  logic [width-1:0] wdata,
  input  logic [width-1:0] mem_out,
  output logic [2:0]       gnt,
  output logic [2:0]       done,
  output logic             wea,
  output logic [addrw-1:0] memaddr,
  output logic [width-1:0] mem_in,
  output logic             wr_take,
  output logic [width-1:0] rdata,
  output logic [2:0]       rvalid,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [lenw-1:0]  cnt;
  logic [1:0]       last;
  logic             win_any;
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic [addrw-1:0] base_sel;
  logic [lenw-1:0]  len_sel;

  // Round-robin pick: scan last+1, last+2, last and take the first active req.
  always_comb begin
    win_any = 1'b0;
    win_idx = last;
    cand    = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      cand = 2'((int'(last) + i) % 3);
      if (!win_any && req[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Burst parameters of the arbitration winner.
  always_comb begin
    case (win_idx)
      2'd0:    begin base_sel = base0; len_sel = len0; end
      2'd1:    begin base_sel = base1; len_sel = len1; end
      default: begin base_sel = base2; len_sel = len2; end
    endcase
  end

  // Sequencer: grant, beat down-counter, address walk and read-valid tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= 3'b000;
      cnt     <= '0;
      memaddr <= '0;
      last    <= 2'd2;
      rvalid  <= 3'b000;
    end else begin
      // read data appears one cycle after each read beat's address
      rvalid <= (state == BURST) ? {1'b0, gnt[1:0]} : 3'b000;
      case (state)
        IDLE: begin
          if (win_any) begin
            gnt  <= 3'(3'b001 << win_idx);
            last <= win_idx;
            cnt  <= len_sel;
            if (len_sel == '0) begin
              // zero-length burst leaves the address where it was
              state <= DRAIN;
            end else begin
              memaddr <= base_sel;
              state   <= BURST;
            end
          end
        end
        BURST: begin
          cnt <= cnt - lenw'(1);
          if (cnt == lenw'(1)) begin
            state <= DRAIN;
          end else begin
            memaddr <= memaddr + addrw'(1);
          end
        end
        DRAIN: begin
          gnt   <= 3'b000;
          state <= IDLE;
        end
        default: begin
          gnt   <= 3'b000;
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decodes of registered state only; req never reaches an output.
  always_comb begin
    busy    = (state != IDLE);
    wea     = (state == BURST) && gnt[2];
    wr_take = wea;
    mem_in  = wea ? wdata : '0;
    done    = (state == DRAIN) ? gnt : 3'b000;
    rdata   = mem_out;
  end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter width, default 8, data width of the BRAM port and write/read data.
REQ-002 SHALL have parameter addrw, default 10, BRAM address width.
REQ-003 SHALL have parameter lenw, default 8, burst-length field width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  3  request lines: [0] input-buffer load (read), [1] weight-buffer load (read), [2] output writeback (write).
REQ-007 SHALL have ports base0, base1, base2  input  addrw each  burst start address per requester.
REQ-008 SHALL have ports len0, len1, len2  input  lenw each  burst beat count per requester.
REQ-009 SHALL have port wdata  input  width  writeback data from requester 2.
REQ-010 SHALL have port mem_out  input  width  BRAM read data, valid one cycle after its address.
REQ-011 SHALL have port gnt  output  3  one-hot grant, held for the whole burst including drain.
REQ-012 SHALL have port done  output  3  one-hot, one-cycle burst-complete pulse.
REQ-013 SHALL have port wea  output  1  BRAM write enable.
REQ-014 SHALL have port memaddr  output  addrw  BRAM address.
REQ-015 SHALL have port mem_in  output  width  BRAM write data.
REQ-016 SHALL have port wr_take  output  1  requester 2 wdata beat consumed this cycle.
REQ-017 SHALL have port rdata  output  width  read data, equal to mem_out.
REQ-018 SHALL have port rvalid  output  3  one-hot tag marking rdata valid for that requester.
REQ-019 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-020 SHALL implement states IDLE, BURST and DRAIN.
REQ-021 In IDLE with any req high, SHALL latch base/len of the winner, assert gnt, and enter BURST next cycle, or DRAIN next cycle if len=0.
REQ-022 Arbitration SHALL be round-robin: priority order is last+1, last+2, last (mod 3), where last is the most recently granted index.
REQ-023 SHALL present memaddr=base, base+1, ... for exactly len consecutive BURST cycles, then enter DRAIN for one cycle, then return to IDLE.
REQ-024 Address increment SHALL wrap modulo 2^addrw (1023 -> 0).
REQ-025 For requester 2, wea and wr_take SHALL be high in every BURST cycle, with mem_in=wdata.
REQ-026 For requesters 0 and 1, wea SHALL be 0.
REQ-027 For requesters 0 and 1, rvalid[grantee] SHALL be high in the cycle after each BURST cycle, i.e. len cycles ending in DRAIN.
REQ-028 done[grantee] SHALL pulse in the DRAIN cycle only, coincident with the last rvalid for reads.
REQ-029 Requesters SHALL hold base/len stable from req rise to done and deassert req by the edge ending DRAIN; the arbiter SHALL sample req only in IDLE.
REQ-030 req deasserted during BURST SHALL be ignored; the burst SHALL complete.
REQ-031 len=0 SHALL produce one DRAIN cycle with gnt and done high, no wea, no rvalid, no wr_take.
REQ-032 Outputs SHALL be registers or decodes of registered state; no combinational path from req to any output.
REQ-033 Burst overhead SHALL be exactly 2 cycles (IDLE + DRAIN) beyond len BURST cycles.
REQ-034 Outside BURST, memaddr SHALL hold its last value and wea SHALL be 0.

Reset
REQ-035 rst low SHALL immediately force state IDLE; gnt, done, rvalid, wea, wr_take and busy to 0; memaddr, mem_in and beat counter to 0; last=2, so requester 0 has first priority.
REQ-036 Reset asserted mid-burst SHALL abort the burst with no done pulse; the first arbitration after rst rises SHALL follow REQ-021 from IDLE.

Verification
REQ-037 req0, base0=1, len0=4, seen in IDLE cycle T -> gnt0 T+1..T+5; memaddr 1,2,3,4 at T+1..T+4; wea=0; rvalid0 T+2..T+5; done0 at T+5; busy low at T+6.
REQ-038 req2, base2=805, len2=3 -> wea and wr_take high 3 cycles at memaddr 805,806,807 with mem_in=wdata each beat; done2 in the following cycle.
REQ-039 req=3'b111 held after reset, each requester drops req after its done and re-raises one cycle later -> grant order 0,1,2,0,1,2, and never two consecutive grants to the same requester.
REQ-040 base1=1022, len1=4 -> memaddr 1022,1023,0,1; rvalid1 four cycles.
REQ-041 len0=0 -> single cycle with gnt0=1, done0=1, wea=0, rvalid=0, then IDLE.
REQ-042 rst low during the third beat of a 6-beat write -> all outputs 0 in the same cycle, no done2; after release, req1 alone is granted at memaddr=base1.
